goertzel_power_detect: RTL and testbench
========================================

Name: goertzel_power_detect

Overview:
Downstream stage of the fixed-bin Goertzel IIR filter. It consumes the filter's frame results (Re/Im of X(k) plus the data-valid flag) and computes |X(k)|^2 = Re^2 + Im^2 with one time-shared multiplier. A hysteresis tone decision with frame-count confirmation follows the power computation. Its outputs feed the tone-detection and control logic.

Parameters:
IW, 32, width of signed Re/Im inputs; matches the Goertzel filter OW.
PW, 2*IW, width of the unsigned power result (localparam, not overridable).
CONF_FRAMES, 3, number of consecutive qualifying frames required to change the tone decision (>=1).
CW, $clog2(CONF_FRAMES+1), confirmation counter width (localparam).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_data_valid  in  1  Goertzel frame-valid; may stay high for several clocks (clken-registered upstream)
i_result_re  in  IW  Re{X(k)}, signed
i_result_im  in  IW  Im{X(k)}, signed
i_thresh_on  in  PW  unsigned power threshold to enter tone state (compare >=)
i_thresh_off  in  PW  unsigned power threshold to leave tone state (compare <)
i_clr_ovr  in  1  synchronous clear of o_overrun
o_power  out  PW  last computed |X|^2, unsigned, registered
o_power_valid  out  1  one-clock pulse when o_power updates
o_tone  out  1  hysteresis tone decision
o_busy  out  1  high while FSM != IDLE
o_overrun  out  1  sticky: a frame arrived while busy and was dropped

Behaviour:
- Clock and reset: one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
- Reset (async assert, any state): FSM=IDLE, all outputs 0, internal registers 0, edge-detect history 0.
- Frame event: rising edge of i_data_valid (registered previous value 0, current 1). A level held high for many clocks is one event.
- FSM states: IDLE, SQ_RE, SQ_IM, DECIDE.
  - IDLE: on event, latch re/im and go to SQ_RE.
  - SQ_RE: acc <= re*re; go to SQ_IM.
  - SQ_IM: acc <= acc + im*im; go to DECIDE.
  - DECIDE: o_power <= acc, o_power_valid <= 1, update hysteresis; go to IDLE.
- Latency: event sampled at edge k; o_power/o_power_valid are visible after edge k+3. o_power_valid is high for exactly one clock.
- Throughput: one frame per 4 clocks max.
- Overrun: an event in SQ_RE/SQ_IM/DECIDE is dropped and o_overrun is set. i_clr_ovr clears it; if set and clear occur in the same cycle, set wins.
- Arithmetic:
  - Single signed IWxIW multiplier, shared between the two squares.
  - Squares are non-negative; the sum fits PW unsigned with no overflow. Maximum is 2^(2IW-1) for re=im=-2^(IW-1).
  - No rounding or truncation.
- Hysteresis, evaluated in DECIDE only, using the new power value:
  - o_tone=0: power >= thresh_on increments on_cnt, otherwise on_cnt=0. When on_cnt reaches CONF_FRAMES, o_tone <= 1 and on_cnt=0.
  - o_tone=1: power < thresh_off increments off_cnt, otherwise off_cnt=0. When off_cnt reaches CONF_FRAMES, o_tone <= 0 and off_cnt=0.
  - o_tone changes on the same edge as o_power_valid.
  - thresh_off > thresh_on is legal and is not checked.
- Thresholds are sampled only in DECIDE and may change at any time.
- o_busy = (state != IDLE), combinational from the state register.

Decomposition:
- Shared include goertzel_pkg.vh holds:
  - FSM state encodings (2-bit).
  - Default IW/CONF_FRAMES constants shared with the Goertzel filter.
- One sub-module: goertzel_hyst_detect. Inputs are power, valid strobe and thresholds; it contains the counters and the tone register. The parent holds the edge detect, FSM, multiplier and accumulator.

Test Plan:
- Reset: hold i_rst_n=0 mid-SQ_IM -> all outputs 0 immediately. After release, first frame re=3, im=-4 -> o_power=25.
- Latency: single-cycle valid with re=3, im=-4 at edge k -> o_power_valid=1 only after edge k+3, o_power=25, o_busy high for 3 clocks.
- Extremes: re=im=-2^31 -> o_power=0x8000_0000_0000_0000. re=2^31-1, im=0 -> 0x3FFF_FFFF_0000_0001.
- Level-held valid: i_data_valid high for 10 clocks -> exactly one o_power_valid, o_overrun=0.
- Overrun: a second rising edge 2 clocks after the first -> dropped, one o_power_valid, o_overrun=1. Assert i_clr_ovr together with a new overrun -> stays 1. Clear alone -> 0.
- Hysteresis (thresh_on=100, thresh_off=50, CONF=3):
  - Powers 144,144,25,144,144 -> o_tone stays 0.
  - Next 144 (third consecutive) -> o_tone=1.
  - Then 60,60,60 -> stays 1.
  - Then 25,25,25 -> o_tone=0 on the third frame's valid.

Source files
------------

// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel power/tone detection path: FSM encodings and
// default widths shared with the upstream Goertzel filter.
package goertzel_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSqRe   = 2'd1,
        StSqIm   = 2'd2,
        StDecide = 2'd3
    } power_state_e;

    localparam int unsigned DefaultIw         = 32;
    localparam int unsigned DefaultConfFrames = 3;

endpackage

// File: rtl/goertzel_hyst_detect.sv
// Hysteresis tone decision: a threshold crossing must persist for CONF_FRAMES consecutive
// power results before the tone output changes.
module goertzel_hyst_detect #(
    parameter int unsigned PW          = 64,
    parameter int unsigned CONF_FRAMES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] power,
    input  logic          strobe,
    input  logic [PW-1:0] thresh_on,
    input  logic [PW-1:0] thresh_off,
    output logic          tone
);

    localparam int unsigned    CW       = $clog2(CONF_FRAMES + 1);
    localparam logic [CW-1:0]  CntLast  = CW'(CONF_FRAMES - 1);

    logic [CW-1:0] on_cnt_q, on_cnt_d;
    logic [CW-1:0] off_cnt_q, off_cnt_d;
    logic          tone_q, tone_d;

    always_comb begin
        on_cnt_d  = on_cnt_q;
        off_cnt_d = off_cnt_q;
        tone_d    = tone_q;
        if (strobe) begin
            if (!tone_q) begin
                if (power >= thresh_on) begin
                    if (on_cnt_q == CntLast) begin
                        tone_d   = 1'b1;
                        on_cnt_d = '0;
                    end else begin
                        on_cnt_d = on_cnt_q + 1'b1;
                    end
                end else begin
                    on_cnt_d = '0;
                end
            end else begin
                if (power < thresh_off) begin
                    if (off_cnt_q == CntLast) begin
                        tone_d    = 1'b0;
                        off_cnt_d = '0;
                    end else begin
                        off_cnt_d = off_cnt_q + 1'b1;
                    end
                end else begin
                    off_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_cnt_q  <= '0;
            off_cnt_q <= '0;
            tone_q    <= 1'b0;
        end else begin
            on_cnt_q  <= on_cnt_d;
            off_cnt_q <= off_cnt_d;
            tone_q    <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/goertzel_power_detect.sv
// Computes |X(k)|^2 from Goertzel frame results with one time-shared squarer, then hands
// each new power value to the hysteresis tone detector.
module goertzel_power_detect
    import goertzel_pkg::*;
#(
    parameter int unsigned IW          = DefaultIw,
    parameter int unsigned CONF_FRAMES = DefaultConfFrames
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_data_valid,
    input  logic [IW-1:0]   i_result_re,
    input  logic [IW-1:0]   i_result_im,
    input  logic [2*IW-1:0] i_thresh_on,
    input  logic [2*IW-1:0] i_thresh_off,
    input  logic            i_clr_ovr,
    output logic [2*IW-1:0] o_power,
    output logic            o_power_valid,
    output logic            o_tone,
    output logic            o_busy,
    output logic            o_overrun
);

    localparam int unsigned PW = 2 * IW;

    power_state_e state_q, state_d;

    logic                 dv_q;
    logic                 frame_evt;
    logic signed [IW-1:0] re_q, im_q;
    logic        [PW-1:0] acc_q;
    logic        [PW-1:0] power_q;
    logic                 pvalid_q;
    logic                 ovr_q;

    logic latch_en, sq_re, sq_im, decide;

    logic signed [IW-1:0] mul_op;
    logic signed [PW-1:0] prod;
    logic        [PW-1:0] sq;

    // A level held high is a single frame; only the 0->1 transition counts.
    assign frame_evt = i_data_valid & ~dv_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (frame_evt) state_d = StSqRe;
            StSqRe:   state_d = StSqIm;
            StSqIm:   state_d = StDecide;
            StDecide: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        latch_en = 1'b0;
        sq_re    = 1'b0;
        sq_im    = 1'b0;
        decide   = 1'b0;
        o_busy   = (state_q != StIdle);
        unique case (state_q)
            StIdle:   latch_en = frame_evt;
            StSqRe:   sq_re    = 1'b1;
            StSqIm:   sq_im    = 1'b1;
            StDecide: decide   = 1'b1;
            default:  ;
        endcase
    end

    // Squares are never negative, so the signed product reinterprets losslessly as unsigned.
    assign mul_op = sq_im ? im_q : re_q;
    assign prod   = mul_op * mul_op;
    assign sq     = $unsigned(prod);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dv_q     <= 1'b0;
            re_q     <= '0;
            im_q     <= '0;
            acc_q    <= '0;
            power_q  <= '0;
            pvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            dv_q     <= i_data_valid;
            pvalid_q <= decide;
            if (latch_en) begin
                re_q <= i_result_re;
                im_q <= i_result_im;
            end
            if (sq_re) acc_q <= sq;
            if (sq_im) acc_q <= acc_q + sq;
            if (decide) power_q <= acc_q;
            if (frame_evt && o_busy) begin
                ovr_q <= 1'b1;
            end else if (i_clr_ovr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    goertzel_hyst_detect #(
        .PW          (PW),
        .CONF_FRAMES (CONF_FRAMES)
    ) u_hyst (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .power      (acc_q),
        .strobe     (decide),
        .thresh_on  (i_thresh_on),
        .thresh_off (i_thresh_off),
        .tone       (o_tone)
    );

    assign o_power       = power_q;
    assign o_power_valid = pvalid_q;
    assign o_overrun     = ovr_q;

endmodule

// File: tb/tb_goertzel_power_detect.sv
// Directed self-checking bench for goertzel_power_detect: latency, arithmetic extremes,
// edge detection, overrun handling, hysteresis and asynchronous reset.
module tb_goertzel_power_detect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv;
    logic [31:0] re, im;
    logic [63:0] thr_on, thr_off;
    logic        clr_ovr;
    logic [63:0] power;
    logic        power_valid, tone, busy, overrun;

    int n_checks = 0;
    int n_errors = 0;

    goertzel_power_detect #(
        .IW          (32),
        .CONF_FRAMES (3)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data_valid  (dv),
        .i_result_re   (re),
        .i_result_im   (im),
        .i_thresh_on   (thr_on),
        .i_thresh_off  (thr_off),
        .i_clr_ovr     (clr_ovr),
        .o_power       (power),
        .o_power_valid (power_valid),
        .o_tone        (tone),
        .o_busy        (busy),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single-cycle frame, then wait (bounded) for the result and check power and tone.
    task automatic frame(input logic [31:0] fre, input logic [31:0] fim,
                         input logic [63:0] exp_p, input logic exp_tone, input string tag);
        logic found;
        found = 1'b0;
        @(negedge clk);
        re = fre;
        im = fim;
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (power_valid) found = 1'b1;
        end
        check({tag, "_valid"}, {63'd0, found}, 64'd1);
        check({tag, "_power"}, power, exp_p);
        check({tag, "_tone"}, {63'd0, tone}, {63'd0, exp_tone});
    endtask

    initial begin
        logic [3:0] busy_seq, valid_seq;
        int         vcount;

        rst_n   = 1'b0;
        dv      = 1'b0;
        re      = '0;
        im      = '0;
        clr_ovr = 1'b0;
        thr_on  = '1;    // keeps hysteresis counters idle until the hysteresis test
        thr_off = '0;
        #1;
        check("rst_power", power, 64'd0);
        check("rst_flags", {60'd0, power_valid, tone, busy, overrun}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Latency: event at edge k, result visible after edge k+3, busy for 3 clocks.
        @(negedge clk);
        re = 32'sd3;
        im = -32'sd4;
        dv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dv           = 1'b0;
            busy_seq[i]  = busy;
            valid_seq[i] = power_valid;
        end
        check("lat_busy", {60'd0, busy_seq}, 64'h7);
        check("lat_valid", {60'd0, valid_seq}, 64'h8);
        check("lat_power", power, 64'd25);
        @(negedge clk);
        check("lat_pulse", {63'd0, power_valid}, 64'd0);

        frame(32'h8000_0000, 32'h8000_0000, 64'h8000_0000_0000_0000, 1'b0, "ext_min");
        frame(32'h7FFF_FFFF, 32'h0, 64'h3FFF_FFFF_0000_0001, 1'b0, "ext_max");

        // Level-held valid is a single frame.
        @(negedge clk);
        re = 32'sd5;
        im = 32'sd12;
        dv = 1'b1;
        vcount = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 9) dv = 1'b0;
            if (power_valid) vcount++;
        end
        check("lvl_count", 64'(vcount), 64'd1);
        check("lvl_power", power, 64'd169);
        check("lvl_ovr", {63'd0, overrun}, 64'd0);

        // Second rising edge two clocks after the first is dropped.
        @(negedge clk);
        re = 32'sd1;
        im = 32'sd1;
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        re = 32'sd9;
        dv = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dv = 1'b0;
            if (power_valid) vcount++;
        end
        check("ovr_count", 64'(vcount), 64'd1);
        check("ovr_power", power, 64'd2);
        check("ovr_set", {63'd0, overrun}, 64'd1);

        // Clear coinciding with a new overrun: set wins.
        @(negedge clk);
        re = 32'sd2;
        im = 32'sd0;
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        dv      = 1'b1;
        clr_ovr = 1'b1;
        @(negedge clk);
        dv      = 1'b0;
        clr_ovr = 1'b0;
        check("ovr_setwins", {63'd0, overrun}, 64'd1);
        repeat (4) @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("ovr_clear", {63'd0, overrun}, 64'd0);
        check("ovr_power2", power, 64'd4);

        // Hysteresis with on=100, off=50, three confirming frames.
        thr_on  = 64'd100;
        thr_off = 64'd50;
        frame(32'sd12, 32'sd0, 64'd144, 1'b0, "hy1");
        frame(32'sd12, 32'sd0, 64'd144, 1'b0, "hy2");
        frame(32'sd3, -32'sd4, 64'd25, 1'b0, "hy3");
        frame(32'sd12, 32'sd0, 64'd144, 1'b0, "hy4");
        frame(32'sd12, 32'sd0, 64'd144, 1'b0, "hy5");
        frame(32'sd12, 32'sd0, 64'd144, 1'b1, "hy6");
        frame(32'sd6, 32'sd5, 64'd61, 1'b1, "hy7");
        frame(32'sd6, 32'sd5, 64'd61, 1'b1, "hy8");
        frame(32'sd6, 32'sd5, 64'd61, 1'b1, "hy9");
        frame(32'sd3, -32'sd4, 64'd25, 1'b1, "hy10");
        frame(32'sd3, -32'sd4, 64'd25, 1'b1, "hy11");
        frame(32'sd3, -32'sd4, 64'd25, 1'b0, "hy12");
        frame(-32'sd10, 32'sd10, 64'd200, 1'b0, "hy13");
        frame(-32'sd10, 32'sd10, 64'd200, 1'b0, "hy14");
        frame(-32'sd10, 32'sd10, 64'd200, 1'b1, "hy15");

        // Asynchronous reset while in SQ_IM clears everything at once.
        @(negedge clk);
        re = 32'sd3;
        im = -32'sd4;
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_power", power, 64'd0);
        check("arst_flags", {60'd0, power_valid, tone, busy, overrun}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(32'sd3, -32'sd4, 64'd25, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
